// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   RV32I decode stage between fetch and execute. Takes one instruction per
//   in_valid/in_ready handshake, cracks fields and immediates, drives the
//   synchronous register file read ports, captures the operands a cycle later
//   and holds a decoded bundle for execute until out_ready.
//   A scoreboard of pending destination writes holds the instruction in DECODE
//   until every source register it uses has been retired by writeback.
//
//   Flow: IDLE -> DECODE (stall on hazard) -> READ -> VALID -> IDLE
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    fetch handshake; in_instr, in_pc
//   rf_raddr1/2          register file read addresses (sampled by RF at the
//                        DECODE->READ edge, data returns on rf_rdata1/2)
//   wb_valid/addr/data   writeback retirement (clears scoreboard bit)
//   out_valid/out_ready  execute handshake; out_* decoded bundle
//
// Build option
//   WB_BYPASS_EN  when defined, a writeback retiring a pending source in the
//                 same cycle releases the stall and its data is forwarded into
//                 the operand, saving one cycle per hazard.
// -----------------------------------------------------------------------------
module decode_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [31:0]     in_pc,
  output logic [4:0]      rf_raddr1,
  output logic [4:0]      rf_raddr2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_pc,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_op1,
  output logic [XLEN-1:0] out_op2,
  output logic            out_illegal
);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_READ, S_VALID} state_t;

  state_t           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_q, pc_d;
  logic [NREG-1:0]  sb_q, sb_d;

  logic [31:0]      out_pc_q, out_pc_d;
  logic [6:0]       out_opcode_q, out_opcode_d;
  logic [2:0]       out_funct3_q, out_funct3_d;
  logic [6:0]       out_funct7_q, out_funct7_d;
  logic [4:0]       out_rd_q, out_rd_d;
  logic             out_wen_q, out_wen_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  logic [XLEN-1:0]  out_op1_q, out_op1_d;
  logic [XLEN-1:0]  out_op2_q, out_op2_d;
  logic             out_illegal_q, out_illegal_d;

  // ---------------------------------------------------------------------------
  // Field cracking of the latched instruction
  // ---------------------------------------------------------------------------
  logic [4:0]  rs1, rs2, rd;
  logic        use_rs1, use_rs2, has_rd, illegal, wen;
  logic [31:0] imm, imm_i, imm_s, imm_b, imm_u, imm_j;

  assign rs1 = instr_q[19:15];
  assign rs2 = instr_q[24:20];
  assign rd  = instr_q[11:7];

  assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                  instr_q[11:8], 1'b0};
  assign imm_u = {instr_q[31:12], 12'h000};
  assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20],
                  instr_q[30:21], 1'b0};

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    has_rd  = 1'b0;
    illegal = 1'b0;
    imm     = '0;
    case (instr_q[6:0])
      OP_REG:                    begin use_rs1 = 1'b1; use_rs2 = 1'b1; has_rd = 1'b1; end
      OP_IMM, OP_LOAD, OP_JALR:  begin use_rs1 = 1'b1; has_rd = 1'b1; imm = imm_i; end
      OP_STORE:                  begin use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_s; end
      OP_BRANCH:                 begin use_rs1 = 1'b1; use_rs2 = 1'b1; imm = imm_b; end
      OP_LUI, OP_AUIPC:          begin has_rd = 1'b1; imm = imm_u; end
      OP_JAL:                    begin has_rd = 1'b1; imm = imm_j; end
      default:                   illegal = 1'b1;
    endcase
  end

  assign wen = has_rd && (rd != 5'd0);

  // ---------------------------------------------------------------------------
  // Hazard check and optional writeback forwarding
  // ---------------------------------------------------------------------------
  logic            hit1, hit2, stall;
  logic [XLEN-1:0] op1_src, op2_src;

`ifdef WB_BYPASS_EN
  logic [XLEN-1:0] byp1_q, byp1_d, byp2_q, byp2_d;
  logic            byp1_vld_q, byp1_vld_d, byp2_vld_q, byp2_vld_d;

  // The RF samples its address at the same edge writeback writes it, so it
  // returns the old value; the retiring data is captured here instead.
  assign hit1 = wb_valid && (wb_addr == rs1);
  assign hit2 = wb_valid && (wb_addr == rs2);

  always_comb begin
    byp1_d     = byp1_q;
    byp2_d     = byp2_q;
    byp1_vld_d = byp1_vld_q;
    byp2_vld_d = byp2_vld_q;
    if (state_q == S_DECODE && !stall) begin
      byp1_vld_d = hit1;
      byp2_vld_d = hit2;
      byp1_d     = wb_data;
      byp2_d     = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp1_q     <= '0;
      byp2_q     <= '0;
      byp1_vld_q <= 1'b0;
      byp2_vld_q <= 1'b0;
    end else begin
      byp1_q     <= byp1_d;
      byp2_q     <= byp2_d;
      byp1_vld_q <= byp1_vld_d;
      byp2_vld_q <= byp2_vld_d;
    end
  end

  assign op1_src = byp1_vld_q ? byp1_q : rf_rdata1;
  assign op2_src = byp2_vld_q ? byp2_q : rf_rdata2;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign hit1    = 1'b0;
  assign hit2    = 1'b0;
  assign op1_src = rf_rdata1;
  assign op2_src = rf_rdata2;
`endif

  // x0 is never pending, so only nonzero used sources can stall.
  assign stall = (use_rs1 && (rs1 != 5'd0) && sb_q[rs1] && !hit1) ||
                 (use_rs2 && (rs2 != 5'd0) && sb_q[rs2] && !hit2);

  // ---------------------------------------------------------------------------
  // Next-state / datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    pc_d          = pc_q;
    sb_d          = sb_q;
    out_pc_d      = out_pc_q;
    out_opcode_d  = out_opcode_q;
    out_funct3_d  = out_funct3_q;
    out_funct7_d  = out_funct7_q;
    out_rd_d      = out_rd_q;
    out_wen_d     = out_wen_q;
    out_imm_d     = out_imm_q;
    out_op1_d     = out_op1_q;
    out_op2_d     = out_op2_q;
    out_illegal_d = out_illegal_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          instr_d = in_instr;
          pc_d    = in_pc;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!stall) state_d = S_READ;
      end
      S_READ: begin
        out_pc_d      = pc_q;
        out_opcode_d  = instr_q[6:0];
        out_funct3_d  = instr_q[14:12];
        out_funct7_d  = instr_q[31:25];
        out_rd_d      = has_rd ? rd : 5'd0;
        out_wen_d     = wen;
        out_imm_d     = imm;
        out_op1_d     = (use_rs1 && (rs1 != 5'd0)) ? op1_src : '0;
        out_op2_d     = (use_rs2 && (rs2 != 5'd0)) ? op2_src : '0;
        out_illegal_d = illegal;
        state_d       = S_VALID;
      end
      S_VALID: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Clear first so a same-edge set of the same bit wins.
    if (wb_valid) sb_d[wb_addr] = 1'b0;
    if (state_q == S_VALID && out_ready && out_wen_q) sb_d[out_rd_q] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      pc_q          <= '0;
      sb_q          <= '0;
      out_pc_q      <= '0;
      out_opcode_q  <= '0;
      out_funct3_q  <= '0;
      out_funct7_q  <= '0;
      out_rd_q      <= '0;
      out_wen_q     <= 1'b0;
      out_imm_q     <= '0;
      out_op1_q     <= '0;
      out_op2_q     <= '0;
      out_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      pc_q          <= pc_d;
      sb_q          <= sb_d;
      out_pc_q      <= out_pc_d;
      out_opcode_q  <= out_opcode_d;
      out_funct3_q  <= out_funct3_d;
      out_funct7_q  <= out_funct7_d;
      out_rd_q      <= out_rd_d;
      out_wen_q     <= out_wen_d;
      out_imm_q     <= out_imm_d;
      out_op1_q     <= out_op1_d;
      out_op2_q     <= out_op2_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready    = (state_q == S_IDLE) && rst_n;
  assign out_valid   = (state_q == S_VALID);
  assign rf_raddr1   = (state_q == S_DECODE && use_rs1) ? rs1 : 5'd0;
  assign rf_raddr2   = (state_q == S_DECODE && use_rs2) ? rs2 : 5'd0;
  assign out_pc      = out_pc_q;
  assign out_opcode  = out_opcode_q;
  assign out_funct3  = out_funct3_q;
  assign out_funct7  = out_funct7_q;
  assign out_rd      = out_rd_q;
  assign out_wen     = out_wen_q;
  assign out_imm     = out_imm_q;
  assign out_op1     = out_op1_q;
  assign out_op2     = out_op2_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//   Bench for decode_stage. Contains a synchronous register file model, a
//   behavioural decode model and a queue of accepted instructions; every
//   bundle handed to execute is compared against the model, and held bundles
//   are checked for stability. Directed cases pin latency and literal values,
//   then a randomized phase mixes hazards, back-pressure and writebacks.
// -----------------------------------------------------------------------------
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [31:0] out_imm, out_op1, out_op2;
  logic        out_illegal;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_rd(out_rd), .out_wen(out_wen), .out_imm(out_imm),
    .out_op1(out_op1), .out_op2(out_op2), .out_illegal(out_illegal)
  );

`ifdef WB_BYPASS_EN
  localparam int WB_LAT = 2;
`else
  localparam int WB_LAT = 3;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ---------------- register file model: read-before-write ----------------
  logic [31:0] rf_mem [32];
  logic [4:0]  ra1_s = 5'd0, ra2_s = 5'd0;
  always @(negedge clk) begin ra1_s = rf_raddr1; ra2_s = rf_raddr2; end
  always @(posedge clk) begin
    rf_rdata1 <= rf_mem[ra1_s];
    rf_rdata2 <= rf_mem[ra2_s];
    if (wb_valid && wb_addr != 5'd0) rf_mem[wb_addr] <= wb_data;
  end

  // ---------------- behavioural decode model ----------------
  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wen, ill, u1, u2;
  } dec_t;

  function automatic dec_t model(input logic [31:0] ins);
    dec_t d;
    int   neg, v;
    d   = '0;
    neg = ins[31] ? 1 : 0;
    v   = 0;
    case (ins[6:0])
      7'h33:               begin d.u1 = 1; d.u2 = 1; d.rd = ins[11:7]; end
      7'h13, 7'h03, 7'h67: begin d.u1 = 1; d.rd = ins[11:7];
                                 v = int'(ins[31:20]) - neg * 4096; end
      7'h23:               begin d.u1 = 1; d.u2 = 1;
                                 v = int'({ins[31:25], ins[11:7]}) - neg * 4096; end
      7'h63:               begin d.u1 = 1; d.u2 = 1;
                                 v = -neg * 4096 + int'(ins[7]) * 2048
                                     + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2; end
      7'h37, 7'h17:        begin d.rd = ins[11:7]; v = int'(ins & 32'hFFFFF000); end
      7'h6F:               begin d.rd = ins[11:7];
                                 v = -neg * (1 << 20) + int'(ins[19:12]) * 4096
                                     + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2; end
      default:             d.ill = 1;
    endcase
    d.imm = v;
    d.wen = (d.rd != 5'd0);
    return d;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  typedef struct packed { logic [31:0] instr, pc; } exp_t;
  exp_t        expq[$];
  int          wbq[$];
  bit          busy [32];
  bit          rand_mode = 0;
  bit          in_fired = 0;
  bit          held = 0;
  logic [151:0] snap;

  wire [151:0] bundle = {out_pc, out_opcode, out_funct3, out_funct7, out_rd, out_wen,
                         out_imm, out_op1, out_op2, out_illegal};

  always @(negedge clk) begin
    if (!rst_n) held = 0;
    else begin
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_bundle", bundle, snap);
      end
      held = 0;
      if (in_valid && in_ready) begin
        exp_t  e;
        dec_t  di;
        e.instr = in_instr; e.pc = in_pc;
        expq.push_back(e);
        di = model(in_instr);
        if (rand_mode && di.wen) busy[di.rd] = 1;
        in_fired = 1;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("unexpected_bundle", expq.size(), 1);
        else begin
          exp_t        e;
          dec_t        d;
          logic [31:0] x1, x2;
          e  = expq.pop_front();
          d  = model(e.instr);
          x1 = (d.u1 && e.instr[19:15] != 0) ? rf_mem[e.instr[19:15]] : 32'd0;
          x2 = (d.u2 && e.instr[24:20] != 0) ? rf_mem[e.instr[24:20]] : 32'd0;
          chk("pc", out_pc, e.pc);
          chk("opcode", out_opcode, e.instr[6:0]);
          chk("funct3", out_funct3, e.instr[14:12]);
          chk("funct7", out_funct7, e.instr[31:25]);
          chk("rd", out_rd, d.rd);
          chk("wen", out_wen, d.wen);
          chk("imm", out_imm, d.imm);
          chk("illegal", out_illegal, d.ill);
          chk("op1", out_op1, x1);
          chk("op2", out_op2, x2);
          if (rand_mode && d.wen) wbq.push_back(int'(d.rd));
        end
      end else if (out_valid) begin
        held = 1;
        snap = bundle;
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick(); @(posedge clk); #1; endtask

  task automatic accept(input logic [31:0] ins, input logic [31:0] pc);
    int n = 0;
    in_valid = 1; in_instr = ins; in_pc = pc;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (n == 50) chk("accept_timeout", 1, 0);
    tick();
    in_valid = 0;
  endtask

  // Cycles counted from the acceptance cycle (or writeback cycle) to out_valid.
  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 60) begin tick(); n++; end
    if (n == 60) chk("valid_timeout", 1, 0);
  endtask

  task automatic release_out();
    out_ready = 1; tick(); out_ready = 0;
  endtask

  task automatic do_wb(input logic [4:0] a, input logic [31:0] v);
    wb_valid = 1; wb_addr = a; wb_data = v; tick(); wb_valid = 0;
  endtask

  task automatic do_reset();
    rst_n = 0; expq.delete(); #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_raddr", {rf_raddr1, rf_raddr2}, 0);
    chk("rst_bundle", bundle, 0);
    tick(); tick();
    rst_n = 1; #1;
    chk("rel_in_ready", in_ready, 1);
  endtask

  localparam int NUM = 300;

  initial begin
    int n;
    int issued = 0;
    in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    for (int i = 0; i < 32; i++) rf_mem[i] = $urandom;
    rf_mem[0] = 32'hDEADBEEF;  // must never reach an operand
    rf_mem[1] = 32'd5;
    rf_mem[2] = 32'd7;
    rst_n = 1;
    #2;
    do_reset();

    // add x3,x1,x2
    accept(32'h002081B3, 32'h100);
    chk("add_raddr1", rf_raddr1, 1);
    chk("add_raddr2", rf_raddr2, 2);
    wait_valid(n);
    chk("add_latency", n, 3);
    chk("add_op1", out_op1, 5);
    chk("add_op2", out_op2, 7);
    chk("add_rd", out_rd, 3);
    chk("add_wen", out_wen, 1);
    chk("add_imm", out_imm, 0);
    release_out();
    do_wb(5'd3, 32'h33);

    // addi x5,x0,1 then add x6,x5,x5 stalls until x5 retires
    accept(32'h00100293, 32'h104);
    wait_valid(n);
    chk("addi_imm", out_imm, 1);
    chk("addi_op1_x0", out_op1, 0);
    release_out();
    accept(32'h00528333, 32'h108);
    repeat (4) begin
      chk("stall_valid", out_valid, 0);
      chk("stall_raddr1", rf_raddr1, 5);
      tick();
    end
    do_wb(5'd5, 32'h11);
    wait_valid(n);
    chk("hazard_latency", n, WB_LAT);
    chk("hazard_op1", out_op1, 32'h11);
    chk("hazard_op2", out_op2, 32'h11);
    release_out();
    do_wb(5'd6, 32'h66);

    // sw x2,-4(x1): negative S immediate, no destination
    accept(32'hFE20AE23, 32'h10C);
    wait_valid(n);
    chk("sw_imm", out_imm, 32'hFFFFFFFC);
    chk("sw_wen", out_wen, 0);
    release_out();
    // add x7,x28,x0 reads the sw rd-field register; it must not be pending
    accept(32'h000E03B3, 32'h110);
    chk("x28_raddr1", rf_raddr1, 28);
    chk("x28_raddr2", rf_raddr2, 0);
    wait_valid(n);
    chk("sw_no_sb_latency", n, 3);
    repeat (5) begin
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    release_out();
    chk("rel_out_valid", out_valid, 0);
    chk("rel_in_ready2", in_ready, 1);
    do_wb(5'd7, 32'h77);

    // illegal encoding
    accept(32'hFFFFFFFF, 32'h114);
    chk("ill_raddr", {rf_raddr1, rf_raddr2}, 0);
    wait_valid(n);
    chk("ill_flag", out_illegal, 1);
    chk("ill_wen", out_wen, 0);
    release_out();

    // reset while stalled on x5
    accept(32'h00100293, 32'h118);
    wait_valid(n);
    release_out();
    accept(32'h00528333, 32'h11C);
    repeat (3) tick();
    chk("pre_rst_stall", out_valid, 0);
    do_reset();
    accept(32'h00528333, 32'h120);
    wait_valid(n);
    chk("sb_cleared_latency", n, 3);
    release_out();

    // ---------------- randomized phase ----------------
    do_reset();
    wbq.delete();
    for (int i = 0; i < 32; i++) busy[i] = 0;
    in_fired = 0;
    rand_mode = 1;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      tick();
      if (in_fired) begin in_valid = 0; in_fired = 0; end
      if (!in_valid && issued < NUM && $urandom_range(0, 3) != 0) begin
        logic [31:0] ins;
        logic [6:0]  op;
        int          r;
        ins = $urandom;
        case ($urandom_range(0, 9))
          0: op = 7'h33; 1: op = 7'h13; 2: op = 7'h03; 3: op = 7'h67; 4: op = 7'h23;
          5: op = 7'h63; 6: op = 7'h37; 7: op = 7'h17; 8: op = 7'h6F;
          default: case ($urandom_range(0, 3))
                     0: op = 7'h7F; 1: op = 7'h0B; 2: op = 7'h2B; default: op = 7'h5B;
                   endcase
        endcase
        r = $urandom_range(0, 31);
        for (int t = 0; t < 64 && busy[r]; t++) r = $urandom_range(0, 31);
        if (busy[r]) r = 0;
        ins[6:0]  = op;
        ins[11:7] = r[4:0];
        in_instr  = ins;
        in_pc     = $urandom;
        in_valid  = 1;
        issued++;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      if (wbq.size() > 0 && $urandom_range(0, 2) == 0) begin
        int r;
        r = wbq.pop_front();
        wb_valid = 1; wb_addr = r[4:0]; wb_data = $urandom;
        busy[r] = 0;
      end else wb_valid = 0;
      if (issued >= NUM && !in_valid && expq.size() == 0 && !out_valid) break;
    end
    chk("drain_queue", expq.size(), 0);
    chk("all_issued", issued, NUM);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
